// File: rtl/serial_subtractor_pkg.sv
// +--------------------------------------------------------------------------+
// | sub_pkg : shared FSM state type and counter sizing for serial_subtractor |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Digit counter width: $clog2 of the digit count, never below one bit.
  function automatic int cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_digit.sv
// +--------------------------------------------------------------------------+
// | digit_subtractor : combinational DIGIT-bit subtract with borrow in/out   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module digit_subtractor #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             brw
);

  // One extra bit on top holds the borrow (it reads as the sign of the result).
  logic [DIGIT:0] full;

  assign full = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, bin};
  assign d    = full[DIGIT-1:0];
  assign brw  = full[DIGIT];

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +--------------------------------------------------------------------------+
// | serial_subtractor : diff = a - b - bin, DIGIT bits per clock, LSD first  |
// | Optional signed-overflow output enabled by defining SUB_OVF_EN.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT and >= 2");
  end

  sub_state_t        state, state_nx;
  logic [WIDTH-1:0]  a_sr, b_sr;
  logic              brw_q;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic              last;
  logic [DIGIT-1:0]  dig_d;
  logic              dig_brw;
  logic [WIDTH+DIGIT-1:0] diff_cat;
  logic [WIDTH-1:0]  diff_nx;

  digit_subtractor #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_d (a_sr[DIGIT-1:0]),
    .b_d (b_sr[DIGIT-1:0]),
    .bin (brw_q),
    .d   (dig_d),
    .brw (dig_brw)
  );

  assign accept   = (state == IDLE) && start;
  assign last     = (cnt == LAST);
  // New digit enters at the MSB end; works even when DIGIT == WIDTH.
  assign diff_cat = {dig_d, diff};
  assign diff_nx  = diff_cat[WIDTH+DIGIT-1:DIGIT];
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      brw_q <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        brw_q <= bin;
        cnt   <= '0;
        diff  <= '0;
        bout  <= 1'b0;
`ifdef SUB_OVF_EN
        ovf   <= 1'b0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        brw_q <= dig_brw;
        cnt   <= cnt + 1'b1;
        diff  <= diff_nx;
        if (last) begin
          bout <= dig_brw;
`ifdef SUB_OVF_EN
          ovf  <= (a_msb != b_msb) && (diff_nx[WIDTH-1] != a_msb);
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire
